wb_retire_ctrl: RTL and testbench
=================================

# wb_retire_ctrl

Writeback-and-retire controller at the consumer end of the MEM/WB pipeline register. It selects the writeback value and drives the register-file write port. It also counts retired instructions and cycles, and turns EBREAK/ECALL/FENCE flags into a stall/drain/halt sequence with a captured exit code for the simulation harness.

## Interface
- DRAIN_CYCLES, 2: cycles between a halting trap and `halted`. Legal range 1..15.
- FENCE_CYCLES, 3: cycles of `stall_req` per FENCE. Legal range 1..15.
- EXIT_REG, 10: architectural register shadowed as the exit code.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wb_valid  in  1  MEM/WB slot holds a real instruction; 0 = bubble.
- wb_pc  in  32  PC of the instruction in WB.
- wb_wb_candidate  in  32  ALU/PC+4 result.
- wb_load_data  in  32  aligned, extended load result.
- wb_csr_data  in  32  CSR read value.
- wb_csr_hit  in  1  CSR address implemented.
- wb_rd_addr  in  5  destination register.
- wb_reg_write  in  1  instruction writes rd.
- wb_wb_sel  in  2  0 = candidate, 1 = load, 2 = CSR, 3 = candidate.
- wb_ebreak, wb_ecall, wb_fence  in  1 each  instruction class flags.
- rf_we  out  1  register-file write enable (combinational).
- rf_waddr  out  5  equals wb_rd_addr (combinational).
- rf_wdata  out  32  selected writeback data (combinational).
- stall_req  out  1  freeze IF/ID/EX (registered state decode).
- halted  out  1  sticky; core finished.
- trap_cause  out  2  0 none, 1 ebreak, 2 ecall.
- halt_pc  out  32  PC of the halting instruction.
- exit_code  out  32  EXIT_REG value at the trap.
- instret  out  64  retired-instruction count.
- cycle  out  64  cycle count.

## Operation
Write data:
- rf_wdata = load_data when sel = 1.
- sel = 2: csr_hit ? csr_data : 0.
- Otherwise rf_wdata = candidate.

rf_we = wb_valid & wb_reg_write & (rd ≠ 0) & (state ∈ {RUN, FENCE_DRAIN}) & !rst.

Shadow register:
- Updates to rf_wdata whenever rf_we and rd == EXIT_REG.
- exit_code captures the shadow value. If the trap-cycle write also targets EXIT_REG, the bypassed new value is captured instead (not possible for EBREAK/ECALL, but must still be implemented).

Retirement:
- An instruction retires when wb_valid is high and state ∈ {RUN, FENCE_DRAIN}.
- instret += 1 per retirement, with 64-bit wrap.
- EBREAK/ECALL retire: they count in instret.

FSM states: RUN, FENCE_DRAIN, HALT_DRAIN, HALTED. A 4-bit down-counter `cnt` supports the drain states.
- RUN or FENCE_DRAIN, valid & ebreak: capture halt_pc and trap_cause = 1. Load cnt = DRAIN_CYCLES and go to HALT_DRAIN.
- Same, valid & ecall (no ebreak): trap_cause = 2; otherwise as for ebreak.
- Priority is ebreak > ecall > fence.
- RUN, valid & fence: load cnt = FENCE_CYCLES and go to FENCE_DRAIN.
- FENCE_DRAIN:
  - Decrement cnt each cycle; at cnt == 1, go to RUN.
  - A new FENCE here reloads cnt.
  - Writes and retirement continue, for instructions already past EX.
- HALT_DRAIN:
  - Decrement cnt each cycle; at cnt == 1, go to HALTED.
  - All WB slots are squashed: no rf_we, no instret increment.
- HALTED: terminal until rst. No writes, no retirement.

Other outputs:
- stall_req = state ≠ RUN.
- halted = (state == HALTED).
- cycle increments every cycle when state ≠ HALTED, and freezes in HALTED.

Reset (async) values:
- state = RUN, cnt = 0.
- instret = 0, cycle = 0.
- halted = 0, stall_req = 0, trap_cause = 0.
- halt_pc = 0, exit_code = 0, shadow = 0.
- rf_we = 0 while rst is high.
- Reset mid-drain or in HALTED returns to RUN immediately.

## Timing
- rf_we, rf_waddr and rf_wdata: same cycle, combinational from the MEM/WB outputs.
- instret and shadow: updated at the edge closing the retiring cycle.
- Trap sampled at edge N:
  - stall_req is high from N.
  - halted is high from edge N + DRAIN_CYCLES.
  - trap_cause, halt_pc and exit_code are valid from N and held stable afterwards.
- Fence sampled at edge N: stall_req is high for exactly FENCE_CYCLES cycles, low again after edge N + FENCE_CYCLES.
- cycle reads 1 after the first edge following reset release.
- It stops at its value at the edge entering HALTED.

## Test plan
- addi x5 = 0x1234 (sel 0, valid), then bubble → rf_we = 1, waddr = 5, wdata = 0x00001234 for one cycle; instret = 1.
- Write to x0 with sel 1 and load_data = 0xDEADBEEF → rf_we = 0; instret still increments.
- sel 2 with csr_hit = 0 and csr_data = 0xFFFFFFFF → rf_wdata = 0.
- Write x10 = 0x2A, then ebreak at pc 0x80000010 (DRAIN_CYCLES = 2):
  - exit_code = 0x2A, trap_cause = 1, halt_pc = 0x80000010.
  - stall_req is high from the ebreak edge.
  - halted is high 2 edges later.
  - An instruction writing x6 during HALT_DRAIN is suppressed.
  - cycle freezes.
- Fence (FENCE_CYCLES = 3):
  - stall_req is high for exactly 3 cycles.
  - A write to x7 during the drain still commits.
  - A second fence during the drain extends the stall to 3 cycles from that edge.
- ebreak and ecall asserted in the same cycle → trap_cause = 1.
- Assert rst while HALTED → all outputs return to their reset values asynchronously.
- Next ecall → trap_cause = 2, and instret restarts counting from 0.

Source files
------------

// File: rtl/wb_retire_ctrl.sv
// Writeback/retire controller: selects register-file write data, counts
// retirements and cycles, and sequences FENCE stalls and EBREAK/ECALL halts.
module wb_retire_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int FENCE_CYCLES = 3,
    parameter int EXIT_REG     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_wb_candidate,
    input  logic [31:0] wb_load_data,
    input  logic [31:0] wb_csr_data,
    input  logic        wb_csr_hit,
    input  logic [4:0]  wb_rd_addr,
    input  logic        wb_reg_write,
    input  logic [1:0]  wb_wb_sel,
    input  logic        wb_ebreak,
    input  logic        wb_ecall,
    input  logic        wb_fence,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        stall_req,
    output logic        halted,
    output logic [1:0]  trap_cause,
    output logic [31:0] halt_pc,
    output logic [31:0] exit_code,
    output logic [63:0] instret,
    output logic [63:0] cycle
);

    typedef enum logic [1:0] {RUN, FENCE_DRAIN, HALT_DRAIN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  trap_cause_q, trap_cause_d;
    logic [31:0] halt_pc_q, halt_pc_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [31:0] shadow_q, shadow_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] cycle_q, cycle_d;

    logic active, retire, trap;

    assign active = (state_q == RUN) || (state_q == FENCE_DRAIN);
    assign retire = wb_valid && active;
    assign trap   = retire && (wb_ebreak || wb_ecall);

    always_comb begin
        case (wb_wb_sel)
            2'd1:    rf_wdata = wb_load_data;
            2'd2:    rf_wdata = wb_csr_hit ? wb_csr_data : 32'd0;
            default: rf_wdata = wb_wb_candidate;
        endcase
    end

    assign rf_waddr = wb_rd_addr;
    assign rf_we    = retire && wb_reg_write && (wb_rd_addr != 5'd0) && !rst;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trap_cause_d = trap_cause_q;
        halt_pc_d    = halt_pc_q;
        exit_code_d  = exit_code_q;
        instret_d    = instret_q + {63'd0, retire};
        cycle_d      = (state_q != HALTED) ? cycle_q + 64'd1 : cycle_q;
        shadow_d     = (rf_we && wb_rd_addr == 5'(EXIT_REG)) ? rf_wdata : shadow_q;

        if (trap) begin
            state_d      = HALT_DRAIN;
            cnt_d        = 4'(DRAIN_CYCLES);
            trap_cause_d = wb_ebreak ? 2'd1 : 2'd2;
            halt_pc_d    = wb_pc;
            // shadow_d already carries a same-cycle write to the exit register
            exit_code_d  = shadow_d;
        end else if (retire && wb_fence) begin
            state_d = FENCE_DRAIN;
            cnt_d   = 4'(FENCE_CYCLES);
        end else if (state_q == FENCE_DRAIN || state_q == HALT_DRAIN) begin
            if (cnt_q <= 4'd1) begin
                state_d = (state_q == FENCE_DRAIN) ? RUN : HALTED;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            cnt_q        <= 4'd0;
            trap_cause_q <= 2'd0;
            halt_pc_q    <= 32'd0;
            exit_code_q  <= 32'd0;
            shadow_q     <= 32'd0;
            instret_q    <= 64'd0;
            cycle_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_cause_q <= trap_cause_d;
            halt_pc_q    <= halt_pc_d;
            exit_code_q  <= exit_code_d;
            shadow_q     <= shadow_d;
            instret_q    <= instret_d;
            cycle_q      <= cycle_d;
        end
    end

    assign stall_req  = (state_q != RUN);
    assign halted     = (state_q == HALTED);
    assign trap_cause = trap_cause_q;
    assign halt_pc    = halt_pc_q;
    assign exit_code  = exit_code_q;
    assign instret    = instret_q;
    assign cycle      = cycle_q;

endmodule

// File: tb/tb_wb_retire_ctrl.sv
// Scoreboarded bench for wb_retire_ctrl: per-cycle write-port expectations are
// queued at drive time and popped at the falling edge; counters tracked locally.
module tb_wb_retire_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_wb_candidate, wb_load_data, wb_csr_data;
    logic        wb_csr_hit;
    logic [4:0]  wb_rd_addr;
    logic        wb_reg_write;
    logic [1:0]  wb_wb_sel;
    logic        wb_ebreak, wb_ecall, wb_fence;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req, halted;
    logic [1:0]  trap_cause;
    logic [31:0] halt_pc, exit_code;
    logic [63:0] instret, cycle;

    wb_retire_ctrl #(.DRAIN_CYCLES(2), .FENCE_CYCLES(3), .EXIT_REG(10)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wb_candidate(wb_wb_candidate),
        .wb_load_data(wb_load_data), .wb_csr_data(wb_csr_data), .wb_csr_hit(wb_csr_hit),
        .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_wb_sel(wb_wb_sel),
        .wb_ebreak(wb_ebreak), .wb_ecall(wb_ecall), .wb_fence(wb_fence),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_req(stall_req), .halted(halted), .trap_cause(trap_cause),
        .halt_pc(halt_pc), .exit_code(exit_code), .instret(instret), .cycle(cycle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    logic [63:0] exp_instret;
    logic [63:0] exp_cycle;
    logic        cyc_frozen;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Drive one WB slot, queue its expected write port, compare at negedge, then clock.
    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic rw, input logic [1:0] sel, input logic [31:0] cand,
                        input logic [31:0] ld, input logic [31:0] csr, input logic hit,
                        input logic eb, input logic ec, input logic fe,
                        input logic exp_we, input logic [31:0] exp_wd, input logic exp_ret);
        wb_exp_t e;
        wb_valid = v; wb_pc = pc; wb_rd_addr = rd; wb_reg_write = rw; wb_wb_sel = sel;
        wb_wb_candidate = cand; wb_load_data = ld; wb_csr_data = csr; wb_csr_hit = hit;
        wb_ebreak = eb; wb_ecall = ec; wb_fence = fe;
        sb_q.push_back('{exp_we, rd, exp_wd});
        @(negedge clk);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk("rf_we", {63'd0, rf_we}, {63'd0, e.we});
            chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.waddr});
            chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.wdata});
        end
        @(posedge clk);
        #1;
        if (exp_ret) exp_instret++;
        if (!cyc_frozen) exp_cycle++;
    endtask

    task automatic bubble();
        step(1'b0, 32'd0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0,
             1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = 64'd0;
        exp_cycle   = 64'd0;
        cyc_frozen  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, {63'd0, stall_req}, 64'd0);
        chk({tag, "_halted"}, {63'd0, halted}, 64'd0);
        chk({tag, "_cause"}, {62'd0, trap_cause}, 64'd0);
        chk({tag, "_hpc"}, {32'd0, halt_pc}, 64'd0);
        chk({tag, "_exit"}, {32'd0, exit_code}, 64'd0);
        chk({tag, "_instret"}, instret, 64'd0);
        chk({tag, "_cycle"}, cycle, 64'd0);
        chk({tag, "_rf_we"}, {63'd0, rf_we}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        wb_valid = 1'b1; wb_pc = 32'd0; wb_rd_addr = 5'd5; wb_reg_write = 1'b1;
        wb_wb_sel = 2'd0; wb_wb_candidate = 32'h1; wb_load_data = 32'd0;
        wb_csr_data = 32'd0; wb_csr_hit = 1'b0;
        wb_ebreak = 1'b0; wb_ecall = 1'b0; wb_fence = 1'b0;
        exp_instret = 64'd0; exp_cycle = 64'd0; cyc_frozen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("rst0");
        rst = 1'b0;

        // Basic writeback paths
        step(1, 32'h100, 5'd5, 1, 2'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h1234, 1);
        chk("cycle_first", cycle, 64'd1);
        chk("instret_addi", instret, exp_instret);
        bubble();
        chk("instret_bubble", instret, exp_instret);
        step(1, 32'h104, 5'd0, 1, 2'd1, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1);
        chk("instret_x0", instret, 64'd2);
        step(1, 32'h108, 5'd3, 1, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 32'h0, 1);
        step(1, 32'h10C, 5'd4, 1, 2'd2, 32'h0, 32'h0, 32'h0000CAFE, 1, 0, 0, 0, 1, 32'h0000CAFE, 1);
        step(1, 32'h110, 5'd8, 1, 2'd3, 32'h55, 32'h1, 32'h2, 1, 0, 0, 0, 1, 32'h55, 1);
        chk("instret_sel", instret, exp_instret);

        // Single fence: stall for exactly 3 cycles, write continues
        step(1, 32'h114, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1);
        chk("fence_n0", {63'd0, stall_req}, 64'd1);
        step(1, 32'h118, 5'd7, 1, 2'd0, 32'h77, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h77, 1);
        chk("fence_n1", {63'd0, stall_req}, 64'd1);
        bubble();
        chk("fence_n2", {63'd0, stall_req}, 64'd1);
        bubble();
        chk("fence_n3", {63'd0, stall_req}, 64'd0);
        chk("instret_fence", instret, exp_instret);

        // Second fence mid-drain restarts the 3-cycle window
        step(1, 32'h120, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1);
        bubble();
        step(1, 32'h124, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 1);
        chk("fence2_m0", {63'd0, stall_req}, 64'd1);
        bubble();
        chk("fence2_m1", {63'd0, stall_req}, 64'd1);
        bubble();
        chk("fence2_m2", {63'd0, stall_req}, 64'd1);
        bubble();
        chk("fence2_m3", {63'd0, stall_req}, 64'd0);

        // x10 = 0x2A then ebreak; drain squashes a write to x6
        step(1, 32'h80000008, 5'd10, 1, 2'd0, 32'h2A, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h2A, 1);
        step(1, 32'h80000010, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0, 1);
        chk("eb_stall", {63'd0, stall_req}, 64'd1);
        chk("eb_halted_n0", {63'd0, halted}, 64'd0);
        chk("eb_cause", {62'd0, trap_cause}, 64'd1);
        chk("eb_hpc", {32'd0, halt_pc}, 64'h80000010);
        chk("eb_exit", {32'd0, exit_code}, 64'h2A);
        chk("eb_instret", instret, exp_instret);
        step(1, 32'h80000014, 5'd6, 1, 2'd0, 32'h66, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h66, 0);
        chk("eb_halted_n1", {63'd0, halted}, 64'd0);
        bubble();
        cyc_frozen = 1'b1;
        chk("eb_halted_n2", {63'd0, halted}, 64'd1);
        chk("eb_cycle_enter", cycle, exp_cycle);
        step(1, 32'h80000018, 5'd6, 1, 2'd0, 32'h67, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h67, 0);
        bubble();
        chk("halt_cycle_frozen", cycle, exp_cycle);
        chk("halt_instret", instret, exp_instret);
        chk("halt_exit_held", {32'd0, exit_code}, 64'h2A);

        // Asynchronous reset while halted, a valid write held on the inputs
        wb_valid = 1'b1; wb_reg_write = 1'b1; wb_rd_addr = 5'd9;
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_instret = 64'd0; exp_cycle = 64'd0; cyc_frozen = 1'b0;
        bubble();

        // ebreak and ecall together: ebreak wins
        step(1, 32'h200, 5'd0, 0, 2'd0, 32'h0, 32'h0, 32'h0, 0, 1, 1, 1, 0, 32'h0, 1);
        chk("both_cause", {62'd0, trap_cause}, 64'd1);
        chk("both_hpc", {32'd0, halt_pc}, 64'h200);

        // ecall after reset; same-cycle write to x10 is bypassed into exit_code
        do_reset();
        chk("rst2_instret", instret, 64'd0);
        step(1, 32'h300, 5'd10, 1, 2'd0, 32'h99, 32'h0, 32'h0, 0, 0, 1, 0, 1, 32'h99, 1);
        chk("ec_cause", {62'd0, trap_cause}, 64'd2);
        chk("ec_instret", instret, 64'd1);
        chk("ec_exit_bypass", {32'd0, exit_code}, 64'h99);
        chk("ec_cycle", cycle, exp_cycle);
        bubble();
        bubble();
        chk("ec_halted", {63'd0, halted}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
